// File: rtl/crypto_seq_pkg.sv
// Shared types and constants for the crypto round sequencer:
// FSM state encoding, round-index width, round limit and round-constant helper.
package crypto_seq_pkg;

    localparam int IDX_W      = 4;
    localparam int MAX_ROUNDS = 8;

    typedef enum logic [1:0] {
        IDLE,
        KEYGEN,
        ROUND,
        DONE
    } seq_state_e;

    // Round constant for key i; only the low byte of the key is affected.
    function automatic logic [7:0] rcon(input logic [IDX_W-1:0] i);
        return 8'h01 << i;
    endfunction

endpackage

// File: rtl/crypto_round_sequencer_if.sv
// Request/response bundle between the execution unit (master) and the
// crypto round sequencer (slave).
interface crypto_round_sequencer_if;

    logic                             start;
    logic                             mode;
    logic [15:0]                      data_in;
    logic [15:0]                      key_in;
    logic                             busy;
    logic                             done;
    logic [15:0]                      data_out;
    logic [crypto_seq_pkg::IDX_W-1:0] round_idx;

    modport master (
        output start, mode, data_in, key_in,
        input  busy, done, data_out, round_idx
    );

    modport slave (
        input  start, mode, data_in, key_in,
        output busy, done, data_out, round_idx
    );

endinterface

// File: rtl/crypto_dec_round.sv
// One decrypt round: add round key, fold with its own swap, byte swap, byte S-box.
module crypto_dec_round (
    input  logic [15:0] blk,
    input  logic [15:0] rk,
    output logic [15:0] res
);

    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;

    assign x = blk ^ rk;
    assign y = x ^ {x[7:0], x[15:8]};
    assign z = {y[7:0], y[15:8]};

    sbox_8bit u_sbox_hi (.din(z[15:8]), .dout(res[15:8]));
    sbox_8bit u_sbox_lo (.din(z[7:0]),  .dout(res[7:0]));

endmodule

// File: rtl/crypto_enc_round.sv
// One encrypt round: byte S-box, byte swap, fold with its own swap, add round key.
module crypto_enc_round (
    input  logic [15:0] blk,
    input  logic [15:0] rk,
    output logic [15:0] res
);

    logic [15:0] sb;
    logic [15:0] sw;

    sbox_8bit u_sbox_hi (.din(blk[15:8]), .dout(sb[15:8]));
    sbox_8bit u_sbox_lo (.din(blk[7:0]),  .dout(sb[7:0]));

    assign sw  = {sb[7:0], sb[15:8]};
    assign res = sw ^ {sw[7:0], sw[15:8]} ^ rk;

endmodule

// File: rtl/crypto_key_expand.sv
// Next round key from the current one: rotate left by 3, then XOR the round
// constant for index idx into the low byte.
module crypto_key_expand
    import crypto_seq_pkg::*;
(
    input  logic [15:0]      key_cur,
    input  logic [IDX_W-1:0] idx,
    output logic [15:0]      key_next
);

    assign key_next = {key_cur[12:0], key_cur[15:13]} ^ {8'h00, rcon(idx)};

endmodule

// File: rtl/sbox_8bit.sv
// Byte substitution shared by the encrypt and decrypt round logic.
module sbox_8bit (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = din ^ {din[6:0], din[7]} ^ {din[4:0], din[7:5]} ^ 8'h53;

endmodule

// File: rtl/crypto_round_sequencer.sv
// Iterates one shared enc/dec round NUM_ROUNDS times after a per-request key
// schedule. Build option CRYPTO_SEQ_KEYCACHE_EN skips the schedule on a repeated key.
module crypto_round_sequencer
    import crypto_seq_pkg::*;
#(
    parameter int NUM_ROUNDS = 4
) (
    input  logic clk,
    input  logic rst,
    crypto_round_sequencer_if.slave bus
);

    // state  | meaning
    // IDLE   | waiting for start; request captured on acceptance
    // KEYGEN | expanding rk[1..N], one key per cycle, round_idx 0..N-1
    // ROUND  | one round per cycle; enc ascends 1..N, dec descends N..1
    // DONE   | done pulse, data_out valid

    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ROUNDS);
    localparam logic [IDX_W-1:0] KEY_LAST = IDX_W'(NUM_ROUNDS - 1);

    seq_state_e       state_q, state_nx;
    logic [IDX_W-1:0] idx_q, idx_nx;
    logic             mode_q, mode_nx;
    logic [15:0]      key_q, key_nx;
    logic [15:0]      work_q, work_nx;
    logic [15:0]      blk_q, blk_nx;
    logic [15:0]      dout_q, dout_nx;

    logic [15:0]      key_next;
    logic [15:0]      rk_cur;
    logic [15:0]      enc_res;
    logic [15:0]      dec_res;
    logic             rk_we;

    // Not reset: contents are only read after a full KEYGEN has refilled them.
    logic [15:0]      rk_mem [0:MAX_ROUNDS];

`ifdef CRYPTO_SEQ_KEYCACHE_EN
    logic [15:0]      ckey_q, ckey_nx;
    logic             cvld_q, cvld_nx;
    logic             cache_hit;

    assign cache_hit = cvld_q && (bus.key_in == ckey_q);
`endif

    crypto_key_expand u_key_expand (
        .key_cur  (work_q),
        .idx      (idx_q),
        .key_next (key_next)
    );

    assign rk_cur = rk_mem[idx_q];

    crypto_enc_round u_enc_round (
        .blk (blk_q),
        .rk  (rk_cur),
        .res (enc_res)
    );

    crypto_dec_round u_dec_round (
        .blk (blk_q),
        .rk  (rk_cur),
        .res (dec_res)
    );

    always_comb begin
        state_nx = state_q;
        idx_nx   = idx_q;
        mode_nx  = mode_q;
        key_nx   = key_q;
        work_nx  = work_q;
        blk_nx   = blk_q;
        dout_nx  = dout_q;
        rk_we    = 1'b0;
`ifdef CRYPTO_SEQ_KEYCACHE_EN
        ckey_nx  = ckey_q;
        cvld_nx  = cvld_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mode_nx  = bus.mode;
                    key_nx   = bus.key_in;
                    work_nx  = bus.key_in;
                    // Decrypt applies rk[0] at the end instead of the start.
                    blk_nx   = bus.mode ? bus.data_in : (bus.data_in ^ bus.key_in);
                    idx_nx   = '0;
                    state_nx = KEYGEN;
`ifdef CRYPTO_SEQ_KEYCACHE_EN
                    if (cache_hit) begin
                        state_nx = ROUND;
                        idx_nx   = bus.mode ? IDX_LAST : IDX_ONE;
                    end else begin
                        // The key file is about to be overwritten.
                        cvld_nx = 1'b0;
                    end
`endif
                end
            end
            KEYGEN: begin
                rk_we   = 1'b1;
                work_nx = key_next;
                idx_nx  = idx_q + IDX_ONE;
                if (idx_q == KEY_LAST) begin
                    state_nx = ROUND;
                    idx_nx   = mode_q ? IDX_LAST : IDX_ONE;
`ifdef CRYPTO_SEQ_KEYCACHE_EN
                    ckey_nx  = key_q;
                    cvld_nx  = 1'b1;
`endif
                end
            end
            ROUND: begin
                if (mode_q) begin
                    blk_nx = dec_res;
                    idx_nx = idx_q - IDX_ONE;
                    if (idx_q == IDX_ONE) begin
                        state_nx = DONE;
                        idx_nx   = idx_q;
                        dout_nx  = dec_res ^ key_q;
                    end
                end else begin
                    blk_nx = enc_res;
                    idx_nx = idx_q + IDX_ONE;
                    if (idx_q == IDX_LAST) begin
                        state_nx = DONE;
                        idx_nx   = idx_q;
                        dout_nx  = enc_res;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
                idx_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                idx_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            key_q   <= '0;
            work_q  <= '0;
            blk_q   <= '0;
            dout_q  <= '0;
`ifdef CRYPTO_SEQ_KEYCACHE_EN
            ckey_q  <= '0;
            cvld_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_nx;
            idx_q   <= idx_nx;
            mode_q  <= mode_nx;
            key_q   <= key_nx;
            work_q  <= work_nx;
            blk_q   <= blk_nx;
            dout_q  <= dout_nx;
`ifdef CRYPTO_SEQ_KEYCACHE_EN
            ckey_q  <= ckey_nx;
            cvld_q  <= cvld_nx;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rk_we) begin
            rk_mem[idx_q + IDX_ONE] <= key_next;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.data_out  = dout_q;
    assign bus.round_idx = idx_q;

endmodule
